cache_axi_rd_arbiter: RTL and testbench
=======================================

// Module: cache_axi_rd_arbiter
// PURPOSE
//  Shares one burst-capable AXI read channel between the instruction cache (master I) and
//  the data cache (master D). Sits between the two cache refill engines and the AXI bridge.
//  Accepts one refill request at a time, drives it to memory, and steers the returned beats
//  to the owner. Data cache has priority; a starvation counter guarantees the I-side progresses.
// PARAMETERS
//  STARVE_LIMIT  8    cycles I may wait with i_arvalid high before it overrides D priority
//  CNT_WIDTH     4    width of starvation and beat counters (must hold STARVE_LIMIT and 15)
//  I_ID          4'd0 arid issued for I-side bursts
//  D_ID          4'd1 arid issued for D-side bursts
// PORTS
//  clk                         in   1       clock
//  rst                         in   1       synchronous reset, active-high
//  i_araddr/i_arlen/i_arsize   in   32/4/3  I-side burst request fields
//  i_arvalid / i_arready       in/out 1/1   I-side request handshake
//  i_rdata / i_rlast           out  32/1    I-side returned beat
//  i_rvalid / i_rready         out/in 1/1   I-side beat handshake
//  d_araddr/d_arlen/d_arsize   in   32/4/3  D-side burst request fields
//  d_arvalid / d_arready       in/out 1/1   D-side request handshake
//  d_rdata / d_rlast           out  32/1    D-side returned beat
//  d_rvalid / d_rready         out/in 1/1   D-side beat handshake
//  m_arid/m_araddr/m_arlen     out  4/32/4  memory-side request id, address, burst length-1
//  m_arsize / m_arburst        out  3/2     size (forwarded), burst type (constant 2'b01 INCR)
//  m_arvalid / m_arready       out/in 1/1   memory-side request handshake
//  m_rid/m_rdata/m_rlast       in   4/32/1  memory-side returned beat
//  m_rvalid / m_rready         in/out 1/1   memory-side beat handshake
//  err                         out  1       sticky protocol error (rid mismatch / beat count)
// BEHAVIOUR
//  Reset: rst sync active-high, clock clk. State->IDLE; all valid/ready outputs, err, counters,
//   latched fields and grant = 0. Reset mid-burst abandons it; no beat forwarded after reset.
//  FSM IDLE -> ADDR -> DATA -> IDLE; exactly one burst outstanding.
//  IDLE: grant G = I if (i_arvalid & (!d_arvalid | starve_cnt>=STARVE_LIMIT)); else D if d_arvalid.
//   Granted x_arready=1 combinationally that cycle (only in IDLE, never both); addr/len/size
//   and G latched; next state ADDR. No request -> stay IDLE, both arready=0.
//  ADDR: m_arvalid=1 with latched fields, m_arid=I_ID/D_ID per G; fields stable until
//   m_arready; on m_arvalid&m_arready -> DATA, beat_cnt=0. m_arvalid=0 in every other state.
//  DATA: m_rready = G's rready; G's rvalid = m_rvalid, rdata/rlast forwarded combinationally;
//   non-granted rvalid=0, rlast=0, rdata=0. Beat = m_rvalid&m_rready; beat_cnt++ per beat.
//   Beat with m_rlast -> IDLE next cycle; new grant possible that IDLE cycle (min 1 idle cycle
//   between bursts). m_rready=0 outside DATA.
//  Latency: request accept (IDLE) -> m_arvalid next cycle; beats pass with zero added latency.
//  err set (sticky until rst) on: beat whose m_rid != issued id; m_rlast with beat_cnt!=len;
//   beat with beat_cnt==len and !m_rlast. Beat still forwarded; FSM still ends on m_rlast.
//  starve_cnt: +1 each cycle i_arvalid=1 and I not granted, saturates at 2^CNT_WIDTH-1;
//   cleared on I grant or when i_arvalid=0.
//  Masters must hold x_arvalid and fields stable until x_arready (caches' addr_ok semantics).
// TESTING
//  I only: i_araddr=0x1FC0_0000, arlen=7 -> i_arready 1 cycle, m_arid=0, 8 beats to I, i_rlast on 8th.
//  Same-cycle I and D, starve_cnt=0 -> D granted first (m_arid=1), I granted IDLE after D rlast.
//  D back-to-back requests 12 cycles with I pending -> I granted once starve_cnt reaches 8.
//  Memory stalls m_arready 5 cycles, m_rvalid gaps, d_rready low 3 cycles -> fields stable, no beat lost.
//  m_rlast on beat 4 of arlen=7 -> err=1 and stays 1; FSM back in IDLE next cycle.
//  rst asserted mid-DATA (beat 3) -> next cycle all outputs 0, IDLE, following requests served normally.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_if.sv
// rtl/cache_axi_rd_arbiter_if.sv - bus bundle for the I/D cache refill read arbiter
// master: the arbiter's view; slave: the caches plus memory bridge around it.
interface cache_axi_rd_arbiter_if;
    logic [31:0] i_araddr;
    logic [3:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready;

    logic [31:0] d_araddr;
    logic [3:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready;

    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;

    logic        err;

    modport master (
        input  i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
        output i_arready, i_rdata, i_rlast, i_rvalid,
        input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
        output d_arready, d_rdata, d_rlast, d_rvalid,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  m_arready, m_rid, m_rdata, m_rlast, m_rvalid,
        output err
    );

    modport slave (
        output i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
        input  i_arready, i_rdata, i_rlast, i_rvalid,
        output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
        input  d_arready, d_rdata, d_rlast, d_rvalid,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output m_arready, m_rid, m_rdata, m_rlast, m_rvalid,
        input  err
    );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// rtl/cache_axi_rd_arbiter.sv - shares one AXI read channel between I-cache and D-cache refills
// One burst outstanding; D has priority unless I has waited STARVE_LIMIT cycles.
module cache_axi_rd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_WIDTH    = 4,
    parameter logic [3:0]  I_ID         = 4'd0,
    parameter logic [3:0]  D_ID         = 4'd1
) (
    input logic clk,
    input logic rst,
    cache_axi_rd_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] STARVE_THR = CNT_WIDTH'(STARVE_LIMIT);

    state_t               state_q, state_d;
    logic                 gnt_d_q, gnt_d_d;   // 1: the data cache owns the current burst
    logic [31:0]          addr_q, addr_d;
    logic [3:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] starve_q, starve_d;
    logic                 err_q, err_d;
    logic                 grant_i, grant_d, rready_sel, beat, last_expected;
    logic [3:0]           cur_id;

    assign grant_i       = (state_q == IDLE) && bus.i_arvalid &&
                           (!bus.d_arvalid || (starve_q >= STARVE_THR));
    assign grant_d       = (state_q == IDLE) && bus.d_arvalid && !grant_i;
    assign cur_id        = gnt_d_q ? D_ID : I_ID;
    assign rready_sel    = gnt_d_q ? bus.d_rready : bus.i_rready;
    assign beat          = (state_q == DATA) && bus.m_rvalid && rready_sel;
    assign last_expected = (beat_cnt_q == CNT_WIDTH'(len_q));

    assign bus.m_arid    = cur_id;
    assign bus.m_araddr  = addr_q;
    assign bus.m_arlen   = len_q;
    assign bus.m_arsize  = size_q;
    assign bus.m_arburst = 2'b01;
    assign bus.err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_d_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_cnt_q <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_d_q    <= gnt_d_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            beat_cnt_q <= beat_cnt_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.i_arvalid || grant_i) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d_d       = gnt_d_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        beat_cnt_d    = beat_cnt_q;
        err_d         = err_q;
        bus.i_arready = 1'b0;
        bus.d_arready = 1'b0;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.i_rlast   = 1'b0;
        bus.i_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rlast   = 1'b0;
        bus.d_rdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    bus.i_arready = 1'b1;
                    gnt_d_d       = 1'b0;
                    addr_d        = bus.i_araddr;
                    len_d         = bus.i_arlen;
                    size_d        = bus.i_arsize;
                    state_d       = ADDR;
                end else if (grant_d) begin
                    bus.d_arready = 1'b1;
                    gnt_d_d       = 1'b1;
                    addr_d        = bus.d_araddr;
                    len_d         = bus.d_arlen;
                    size_d        = bus.d_arsize;
                    state_d       = ADDR;
                end
            end
            ADDR: begin
                bus.m_arvalid = 1'b1;
                if (bus.m_arready) begin
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                bus.m_rready = rready_sel;
                if (gnt_d_q) begin
                    bus.d_rvalid = bus.m_rvalid;
                    bus.d_rlast  = bus.m_rlast;
                    bus.d_rdata  = bus.m_rdata;
                end else begin
                    bus.i_rvalid = bus.m_rvalid;
                    bus.i_rlast  = bus.m_rlast;
                    bus.i_rdata  = bus.m_rdata;
                end
                // Protocol violations are flagged but the burst still ends on the memory's rlast.
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if ((bus.m_rid != cur_id) || (bus.m_rlast != last_expected)) begin
                        err_d = 1'b1;
                    end
                    if (bus.m_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb/tb_cache_axi_rd_arbiter.sv - directed scoreboard bench for cache_axi_rd_arbiter
module tb_cache_axi_rd_arbiter;
    logic clk = 1'b0;
    logic rst;
    cache_axi_rd_arbiter_if bus();

    cache_axi_rd_arbiter #(.STARVE_LIMIT(8), .CNT_WIDTH(4), .I_ID(4'd0), .D_ID(4'd1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ar_stall = 0;
    int early_last = -1;
    bit gap_en = 1'b0;

    logic [32:0] exp_i[$];
    logic [32:0] exp_d[$];
    logic [3:0]  id_q[$];
    logic [31:0] aaddr_q[$];
    bit          order_q[$];
    bit          d_keep = 1'b0;
    bit          i_acc_seen, last_prev = 1'b0, prev_wait = 1'b0;
    logic [42:0] prev_fields = '0;
    int          i_beats = 0, d_beats = 0, d_while_i = 0, ar_wait = 0;
    int          i_acc_cyc = 0, d_last_cyc = 0;

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    initial begin
        logic ar_hs_s, r_hs_s, r_last_s, rst_s;
        logic [31:0] a_s, b_addr;
        logic [3:0] l_s, id_s, b_len, b_id;
        int beat, stall;
        bit pending;
        pending = 1'b0; beat = 0; stall = 0;
        b_addr = '0; b_len = '0; b_id = '0;
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        bus.m_rdata = '0; bus.m_rid = '0;
        forever begin
            @(negedge clk);
            rst_s    = rst;
            ar_hs_s  = bus.m_arvalid & bus.m_arready;
            r_hs_s   = bus.m_rvalid & bus.m_rready;
            r_last_s = bus.m_rlast;
            a_s = bus.m_araddr; l_s = bus.m_arlen; id_s = bus.m_arid;
            @(posedge clk);
            #1;
            if (rst_s) begin
                pending = 1'b0; beat = 0; stall = 0;
                bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
                bus.m_rdata = '0; bus.m_rid = '0;
            end else begin
                if (ar_hs_s) begin
                    pending = 1'b1; b_addr = a_s; b_len = l_s; b_id = id_s;
                    beat = 0; stall = 0; bus.m_arready = 1'b0;
                end else if (!pending && bus.m_arvalid) begin
                    if (stall < ar_stall) begin
                        stall++;
                        bus.m_arready = 1'b0;
                    end else begin
                        bus.m_arready = 1'b1;
                    end
                end
                if (r_hs_s) begin
                    beat++;
                    if (r_last_s) pending = 1'b0;
                end
                if (!pending) begin
                    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
                end else if (!(bus.m_rvalid && !r_hs_s)) begin
                    if (gap_en && ($urandom_range(0, 2) == 0)) begin
                        bus.m_rvalid = 1'b0;
                    end else begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = b_addr + 32'(4 * beat);
                        bus.m_rlast  = (beat == int'(b_len)) || (beat == early_last);
                        bus.m_rid    = b_id;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_req(input bit side, input logic [31:0] addr, input logic [3:0] len);
        int n;
        n = (early_last >= 0) ? early_last + 1 : int'(len) + 1;
        for (int k = 0; k < n; k++) begin
            if (side) exp_d.push_back({k == n - 1, addr + 32'(4 * k)});
            else      exp_i.push_back({k == n - 1, addr + 32'(4 * k)});
        end
        id_q.push_back(side ? 4'd1 : 4'd0);
        aaddr_q.push_back(addr);
        order_q.push_back(side);
    endtask

    task automatic step();
        bit i_acc, d_acc, last_now;
        logic [32:0] e;
        logic [3:0] eid;
        logic [31:0] ea;
        @(negedge clk);
        cyc++;
        i_acc = bus.i_arvalid & bus.i_arready;
        d_acc = bus.d_arvalid & bus.d_arready;
        i_acc_seen = i_acc;
        chk("arready_excl", (bus.i_arready & bus.d_arready) === 1'b0);
        chk("rvalid_excl", (bus.i_rvalid & bus.d_rvalid) === 1'b0);
        if (last_prev) chk("idle_after_last", {bus.m_arvalid, bus.m_rready} === 2'b00);
        if (prev_wait) chk("ar_fields_stable",
            {bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize} === prev_fields);
        if (i_acc) begin
            push_req(1'b0, bus.i_araddr, bus.i_arlen);
            i_acc_cyc = cyc;
        end
        if (d_acc) begin
            push_req(1'b1, bus.d_araddr, bus.d_arlen);
            if (bus.i_arvalid) d_while_i++;
        end
        if (bus.m_arvalid && !bus.m_arready) ar_wait++;
        if (bus.m_arvalid && bus.m_arready) begin
            chk("ar_expected", (id_q.size() > 0) === 1'b1);
            if (id_q.size() > 0) begin
                eid = id_q.pop_front();
                ea  = aaddr_q.pop_front();
                chk("m_arid", bus.m_arid === eid);
                chk("m_araddr", bus.m_araddr === ea);
                chk("m_arburst", bus.m_arburst === 2'b01);
            end
        end
        prev_wait   = bus.m_arvalid & !bus.m_arready;
        prev_fields = {bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize};
        last_now = 1'b0;
        if (bus.i_rvalid && bus.i_rready) begin
            chk("i_beat_expected", (exp_i.size() > 0) === 1'b1);
            if (exp_i.size() > 0) begin
                e = exp_i.pop_front();
                chk("i_rdata", bus.i_rdata === e[31:0]);
                chk("i_rlast", bus.i_rlast === e[32]);
            end
            i_beats++;
            last_now = bus.i_rlast;
        end
        if (bus.d_rvalid && bus.d_rready) begin
            chk("d_beat_expected", (exp_d.size() > 0) === 1'b1);
            if (exp_d.size() > 0) begin
                e = exp_d.pop_front();
                chk("d_rdata", bus.d_rdata === e[31:0]);
                chk("d_rlast", bus.d_rlast === e[32]);
            end
            d_beats++;
            if (bus.d_rlast) d_last_cyc = cyc;
            last_now = last_now | bus.d_rlast;
        end
        last_prev = last_now;
        @(posedge clk);
        #1;
        if (i_acc) bus.i_arvalid = 1'b0;
        if (d_acc) begin
            if (d_keep) bus.d_araddr = bus.d_araddr + 32'h100;
            else        bus.d_arvalid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            step();
            n++;
            done = (exp_i.size() == 0) && (exp_d.size() == 0) && (id_q.size() == 0) &&
                   !bus.i_arvalid && !bus.d_arvalid;
        end
        chk(tag, done === 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arsize = '0; bus.i_arvalid = 1'b0; bus.i_rready = 1'b1;
        bus.d_araddr = '0; bus.d_arlen = '0; bus.d_arsize = '0; bus.d_arvalid = 1'b0; bus.d_rready = 1'b1;
        repeat (3) step();
        chk("rst_m_arvalid", bus.m_arvalid === 1'b0);
        chk("rst_m_rready", bus.m_rready === 1'b0);
        chk("rst_err", bus.err === 1'b0);
        chk("rst_rvalid", {bus.i_rvalid, bus.d_rvalid} === 2'b00);
        chk("rst_m_arid", bus.m_arid === 4'd0);
        rst = 1'b0;
        step();

        bus.i_araddr = 32'h1FC0_0000; bus.i_arlen = 4'd7; bus.i_arsize = 3'd2; bus.i_arvalid = 1'b1;
        i_beats = 0;
        step();
        chk("t1_accept", i_acc_seen === 1'b1);
        chk("t1_m_arvalid_next", bus.m_arvalid === 1'b1);
        chk("t1_m_arlen", bus.m_arlen === 4'd7);
        chk("t1_m_arsize", bus.m_arsize === 3'd2);
        drain("t1_drain");
        chk("t1_beats", i_beats === 8);

        order_q.delete();
        bus.i_araddr = 32'h0000_1000; bus.i_arlen = 4'd3; bus.i_arvalid = 1'b1;
        bus.d_araddr = 32'h0000_2000; bus.d_arlen = 4'd1; bus.d_arsize = 3'd2; bus.d_arvalid = 1'b1;
        drain("t2_drain");
        chk("t2_order_len", order_q.size() === 2);
        if (order_q.size() == 2) begin
            chk("t2_first_d", order_q[0] === 1'b1);
            chk("t2_second_i", order_q[1] === 1'b0);
        end
        chk("t2_i_after_d_last", (i_acc_cyc - d_last_cyc) === 1);

        d_while_i = 0;
        bus.d_araddr = 32'h0001_0000; bus.d_arlen = 4'd0; bus.d_arvalid = 1'b1; d_keep = 1'b1;
        bus.i_araddr = 32'h0002_0000; bus.i_arlen = 4'd1; bus.i_arvalid = 1'b1;
        i_acc_seen = 1'b0;
        for (int n = 0; n < 60 && !i_acc_seen; n++) step();
        chk("t3_i_granted", i_acc_seen === 1'b1);
        d_keep = 1'b0;
        drain("t3_drain");
        chk("t3_d_grants_before_i", d_while_i === 3);

        ar_stall = 5; gap_en = 1'b1; ar_wait = 0; d_beats = 0;
        bus.d_araddr = 32'h0000_3000; bus.d_arlen = 4'd7; bus.d_arvalid = 1'b1;
        for (int n = 0; n < 100 && d_beats < 2; n++) step();
        bus.d_rready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_m_rready_follows", bus.m_rready === 1'b0);
        end
        bus.d_rready = 1'b1;
        drain("t4_drain");
        chk("t4_ar_wait", ar_wait === 5);
        chk("t4_d_beats", d_beats === 8);
        chk("t4_no_err", bus.err === 1'b0);
        ar_stall = 0; gap_en = 1'b0;

        early_last = 4;
        bus.i_araddr = 32'h0000_4000; bus.i_arlen = 4'd7; bus.i_arvalid = 1'b1;
        drain("t5_drain");
        chk("t5_err_set", bus.err === 1'b1);
        early_last = -1;
        bus.i_araddr = 32'h0000_4800; bus.i_arlen = 4'd1; bus.i_arvalid = 1'b1;
        drain("t5_drain2");
        chk("t5_err_sticky", bus.err === 1'b1);

        i_beats = 0;
        bus.i_araddr = 32'h0000_5000; bus.i_arlen = 4'd7; bus.i_arvalid = 1'b1;
        for (int n = 0; n < 60 && i_beats < 3; n++) step();
        chk("t6_three_beats", i_beats === 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_m_arvalid", bus.m_arvalid === 1'b0);
        chk("t6_m_rready", bus.m_rready === 1'b0);
        chk("t6_rvalid", {bus.i_rvalid, bus.d_rvalid} === 2'b00);
        chk("t6_rdata", bus.i_rdata === 32'h0);
        chk("t6_err_cleared", bus.err === 1'b0);
        exp_i.delete(); exp_d.delete(); id_q.delete(); aaddr_q.delete();
        last_prev = 1'b0; prev_wait = 1'b0;
        for (int n = 0; n < 4; n++) step();
        bus.d_araddr = 32'h0000_6000; bus.d_arlen = 4'd2; bus.d_arvalid = 1'b1;
        d_beats = 0;
        drain("t6_drain");
        chk("t6_d_beats", d_beats === 3);
        chk("t6_err_clean", bus.err === 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
